mem_stage: RTL and testbench

- MEM pipeline stage of the 5-stage LoongArch core. Sits between EXE and WB.
- Receives the EXE→MEM bus and the synchronous data-SRAM read data, which returns the cycle after EXE issues the address.
- Performs load byte/half selection and extension, and merges the result.
- Reports a MEM-level exception to EXE so EXE can squash stores, drives the forwarding/hazard bus to ID, and forwards everything to WB under valid/allowin handshaking.

---
 rtl/mem_stage_if.sv | 13 +
 rtl/mem_stage.sv | 158 +++++++++++++++
 tb/tb_mem_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Pipeline link between two stages: valid/bus travel downstream, allowin travels upstream.
// The same interface carries EXE->MEM (179-bit bus) and MEM->WB (173-bit bus).
interface mem_stage_if #(
    parameter int BUS_W = 32
);
    logic             valid;
    logic [BUS_W-1:0] bus;
    logic             allowin;

    // master sends an instruction downstream, slave accepts it
    modport master (output valid, output bus, input allowin);
    modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage LoongArch pipeline: load extraction, exception gating, MEM->WB handoff.
// Optional MEM_FWD_EN: forward final_result to ID; otherwise ID sees a zeroed data field.
module mem_stage #(
    parameter int ES_BUS_W = 179,
    parameter int MS_BUS_W = 173
) (
    input  logic               clk,
    input  logic               reset,
    mem_stage_if.slave         es_to_ms,
    mem_stage_if.master        ms_to_ws,
    input  logic [31:0]        data_sram_rdata,
    output logic               mem_ex,
    input  logic               wb_ex,
    input  logic               wb_ertn,
    // {ms_valid, gr_we_eff, is_load, dest[4:0], final_result[31:0]} = 40 bits
    output logic [39:0]        ms_fwd_bus
);

    typedef enum logic {
        FRESH = 1'b0,
        HELD  = 1'b1
    } hold_state_t;

    logic                r_ms_valid;
    logic [ES_BUS_W-1:0] r_bus;
    logic [31:0]         r_rdata_hold;
    hold_state_t         r_hold_state;
    hold_state_t         w_hold_next;

    logic        w_flush;
    logic        w_ms_ready_go;
    logic        w_ms_allowin;
    logic        w_capture;
    logic        w_hold_load;
    logic [31:0] w_load_raw;
    logic [31:0] w_load_data;
    logic [31:0] w_final;
    logic        w_exc;
    logic        w_gr_we_eff;

    logic        w_has_int;
    logic [3:0]  w_exc_op;
    logic [31:0] w_rj;
    logic [31:0] w_rkd;
    logic [33:0] w_csr_data;
    logic [4:0]  w_ld_op;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;
    logic [31:0] w_result;
    logic [31:0] w_pc;
    logic [1:0]  w_addr_lo;

    assign {w_has_int, w_exc_op, w_rj, w_rkd, w_csr_data, w_ld_op,
            w_res_from_mem, w_gr_we, w_dest, w_result, w_pc} = r_bus;
    assign w_addr_lo = w_result[1:0];

    assign w_flush       = wb_ex | wb_ertn;
    assign w_ms_ready_go = 1'b1;
    assign w_ms_allowin  = !r_ms_valid || (w_ms_ready_go && ms_to_ws.allowin);
    assign w_capture     = es_to_ms.valid && w_ms_allowin && !w_flush;

    assign es_to_ms.allowin = w_ms_allowin;
    assign ms_to_ws.valid   = r_ms_valid && w_ms_ready_go && !w_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid   <= 1'b0;
            r_bus        <= '0;
            r_rdata_hold <= '0;
        end else begin
            if (w_flush) begin
                r_ms_valid <= 1'b0;
            end else if (w_ms_allowin) begin
                r_ms_valid <= es_to_ms.valid;
            end
            if (w_capture) begin
                r_bus <= es_to_ms.bus;
            end
            if (w_hold_load) begin
                r_rdata_hold <= data_sram_rdata;
            end
        end
    end

    // SRAM data is only valid one cycle after capture; keep it across a WB stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_state <= FRESH;
        end else begin
            r_hold_state <= w_hold_next;
        end
    end

    always_comb begin
        w_hold_next = r_hold_state;
        w_hold_load = 1'b0;
        w_load_raw  = data_sram_rdata;
        case (r_hold_state)
            FRESH: begin
                if (r_ms_valid && !w_ms_allowin) begin
                    w_hold_next = HELD;
                    w_hold_load = 1'b1;
                end
            end
            HELD: begin
                w_load_raw = r_rdata_hold;
                if (w_capture) begin
                    w_hold_next = FRESH;
                end
            end
            default: w_hold_next = FRESH;
        endcase
        if (w_flush) begin
            w_hold_next = FRESH;
            w_hold_load = 1'b0;
        end
    end

    logic [7:0]  w_byte [4];
    logic [15:0] w_half [2];

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign w_byte[gi] = w_load_raw[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
        assign w_half[gi] = w_load_raw[16*gi +: 16];
    end

    // ld_op = {ld_b, ld_bu, ld_h, ld_hu, ld_w}; ld_w and ld_op==0 both return the word
    always_comb begin
        w_load_data = w_load_raw;
        case (w_ld_op)
            5'b10000: w_load_data = {{24{w_byte[w_addr_lo][7]}}, w_byte[w_addr_lo]};
            5'b01000: w_load_data = {24'd0, w_byte[w_addr_lo]};
            5'b00100: w_load_data = {{16{w_half[w_addr_lo[1]][15]}}, w_half[w_addr_lo[1]]};
            5'b00010: w_load_data = {16'd0, w_half[w_addr_lo[1]]};
            default:  w_load_data = w_load_raw;
        endcase
    end

    assign w_final     = w_res_from_mem ? w_load_data : w_result;
    assign w_exc       = w_has_int || (|w_exc_op);
    assign w_gr_we_eff = w_gr_we && !w_exc;
    assign mem_ex      = r_ms_valid && w_exc;

    assign ms_to_ws.bus = {w_has_int, w_exc_op, w_rj, w_rkd, w_csr_data,
                           w_gr_we_eff, w_dest, w_final, w_pc};

`ifdef MEM_FWD_EN
    assign ms_fwd_bus = {r_ms_valid, r_ms_valid && w_gr_we_eff,
                         r_ms_valid && w_res_from_mem, w_dest, w_final};
`else
    assign ms_fwd_bus = {r_ms_valid, r_ms_valid && w_gr_we_eff,
                         r_ms_valid && w_res_from_mem, w_dest, 32'd0};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed + random bench for mem_stage; reference model indexes a per-cycle log of SRAM data.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_ex;
    logic        wb_ertn;
    logic        mem_ex;
    logic [31:0] data_sram_rdata;
    logic [39:0] ms_fwd_bus;

    mem_stage_if #(.BUS_W(179)) es_if ();
    mem_stage_if #(.BUS_W(173)) ws_if ();

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .es_to_ms        (es_if),
        .ms_to_ws        (ws_if),
        .data_sram_rdata (data_sram_rdata),
        .mem_ex          (mem_ex),
        .wb_ex           (wb_ex),
        .wb_ertn         (wb_ertn),
        .ms_fwd_bus      (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // model: instruction in MEM, and the cycle whose SRAM data belongs to it
    bit           m_valid = 1'b0;
    logic [178:0] m_bus   = '0;
    int           m_cap   = 0;
    int           cyc     = 0;
    logic [31:0]  rdata_log [0:4095];

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [178:0] mk_bus(input bit hi, input logic [3:0] exc, input logic [4:0] ld,
                                            input bit rfm, input bit we, input logic [4:0] dest,
                                            input logic [31:0] result, input logic [31:0] pc);
        logic [31:0] rj, rkd;
        logic [33:0] csr;
        rj  = $urandom;
        rkd = $urandom;
        csr = {2'($urandom_range(0, 3)), 32'($urandom)};
        return {hi, exc, rj, rkd, csr, ld, rfm, we, dest, result, pc};
    endfunction

    // result selection from the architectural load rules, using plain arithmetic
    function automatic logic [31:0] ref_final(input logic [178:0] b, input logic [31:0] rd);
        int unsigned a, bv, hv;
        logic [31:0] r;
        logic [4:0]  ld;
        if (!b[70]) return b[63:32];
        a  = 32'(b[33:32]);
        ld = b[75:71];
        bv = (rd >> (8 * a)) & 32'hFF;
        hv = (rd >> (16 * (a / 2))) & 32'hFFFF;
        case (ld)
            5'b10000: r = (bv >= 128) ? bv - 256 : bv;
            5'b01000: r = bv;
            5'b00100: r = (hv >= 32768) ? hv - 65536 : hv;
            5'b00010: r = hv;
            default:  r = rd;
        endcase
        return r;
    endfunction

    task automatic drive(input bit v, input logic [178:0] b, input bit wa, input logic [31:0] rd);
        reset           = 1'b0;
        wb_ex           = 1'b0;
        wb_ertn         = 1'b0;
        es_if.valid     = v;
        es_if.bus       = b;
        ws_if.allowin   = wa;
        data_sram_rdata = rd;
    endtask

    task automatic settle();
        bit          exc, we_eff, fl;
        logic [31:0] fin;
        rdata_log[cyc] = data_sram_rdata;
        #1;
        exc    = m_bus[178] || (|m_bus[177:174]);
        we_eff = m_bus[69] && !exc;
        fl     = wb_ex || wb_ertn;
        fin    = ref_final(m_bus, rdata_log[m_cap]);
        chk("allowin", 192'(es_if.allowin), 192'(!m_valid || ws_if.allowin));
        chk("to_ws_valid", 192'(ws_if.valid), 192'(m_valid && !fl));
        chk("mem_ex", 192'(mem_ex), 192'(m_valid && exc));
        chk("fwd_ctl", 192'(ms_fwd_bus[39:37]), 192'({m_valid, m_valid && we_eff, m_valid && m_bus[70]}));
`ifndef MEM_FWD_EN
        chk("fwd_data_zero", 192'(ms_fwd_bus[31:0]), 192'(0));
`endif
        if (m_valid) begin
            chk("bus_hi", 192'(ws_if.bus[172:64]), 192'({m_bus[178:76], we_eff, m_bus[68:64]}));
            chk("bus_pc", 192'(ws_if.bus[31:0]), 192'(m_bus[31:0]));
            chk("fwd_dest", 192'(ms_fwd_bus[36:32]), 192'(m_bus[68:64]));
            if (!exc) begin
                chk("final_result", 192'(ws_if.bus[63:32]), 192'(fin));
`ifdef MEM_FWD_EN
                chk("fwd_data", 192'(ms_fwd_bus[31:0]), 192'(fin));
`endif
            end
        end
    endtask

    task automatic tick();
        bit fl, alw;
        @(posedge clk);
        fl  = wb_ex || wb_ertn;
        alw = !m_valid || ws_if.allowin;
        if (reset) begin
            m_valid = 1'b0;
            m_bus   = '0;
        end else if (fl) begin
            m_valid = 1'b0;
        end else if (alw) begin
            m_valid = es_if.valid;
            if (es_if.valid) begin
                m_bus = es_if.bus;
                m_cap = cyc + 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        logic [4:0]  ld;
        int          k;
        bit          rfm;

        drive(1'b0, '0, 1'b1, 32'h0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_allowin", 192'(es_if.allowin), 192'(1));
        chk("rst_to_ws_valid", 192'(ws_if.valid), 192'(0));
        chk("rst_mem_ex", 192'(mem_ex), 192'(0));
        chk("rst_fwd", 192'(ms_fwd_bus), 192'(0));
        @(negedge clk);

        // ld_b from byte 3
        drive(1, mk_bus(0, 4'd0, 5'b10000, 1, 1, 5'd3, 32'h1003, 32'h1c00_0000), 1, $urandom);
        step();
        drive(0, '0, 1, 32'h80FF_0011);
        settle();
        chk("tp_ldb_final", 192'(ws_if.bus[63:32]), 192'(32'hFFFF_FF80));
        chk("tp_ldb_we", 192'(ws_if.bus[69]), 192'(1));
        tick();

        // ld_hu then ld_h back to back, upper half
        drive(1, mk_bus(0, 4'd0, 5'b00010, 1, 1, 5'd4, 32'h2002, 32'h1c00_0004), 1, $urandom);
        step();
        drive(1, mk_bus(0, 4'd0, 5'b00100, 1, 1, 5'd5, 32'h2002, 32'h1c00_0008), 1, 32'hBEEF_1234);
        settle();
        chk("tp_ldhu_final", 192'(ws_if.bus[63:32]), 192'(32'h0000_BEEF));
        tick();
        drive(0, '0, 1, 32'hBEEF_1234);
        settle();
        chk("tp_ldh_final", 192'(ws_if.bus[63:32]), 192'(32'hFFFF_BEEF));
        tick();

        // ld_w stalled by WB for 3 cycles while SRAM data moves on
        drive(1, mk_bus(0, 4'd0, 5'b00001, 1, 1, 5'd6, 32'h3000, 32'h1c00_000c), 1, $urandom);
        step();
        drive(0, '0, 0, 32'hCAFE_F00D);
        step();
        drive(0, '0, 0, 32'h0);
        step();
        step();
        drive(0, '0, 1, 32'h0);
        settle();
        chk("tp_stall_final", 192'(ws_if.bus[63:32]), 192'(32'hCAFE_F00D));
        chk("tp_stall_valid", 192'(ws_if.valid), 192'(1));
        tick();
        settle();
        chk("tp_stall_valid_once", 192'(ws_if.valid), 192'(0));
        tick();

        // ALE from EXE suppresses the register write
        drive(1, mk_bus(0, 4'b0001, 5'b00001, 1, 1, 5'd7, 32'h4001, 32'h1c00_0010), 1, $urandom);
        step();
        drive(0, '0, 1, $urandom);
        settle();
        chk("tp_ale_mem_ex", 192'(mem_ex), 192'(1));
        chk("tp_ale_bus_we", 192'(ws_if.bus[69]), 192'(0));
        chk("tp_ale_fwd_we", 192'(ms_fwd_bus[38]), 192'(0));
        tick();

        // WB exception flush during a stall
        drive(1, mk_bus(0, 4'd0, 5'b00001, 1, 1, 5'd8, 32'h5000, 32'h1c00_0014), 1, $urandom);
        step();
        drive(0, '0, 0, 32'h1111_2222);
        step();
        drive(0, '0, 0, $urandom);
        wb_ex = 1'b1;
        step();
        drive(0, '0, 1, $urandom);
        settle();
        chk("tp_flush_valid", 192'(ws_if.valid), 192'(0));
        chk("tp_flush_mem_ex", 192'(mem_ex), 192'(0));
        chk("tp_flush_allowin", 192'(es_if.allowin), 192'(1));
        tick();
        drive(1, mk_bus(0, 4'd0, 5'b00001, 1, 1, 5'd9, 32'h5004, 32'h1c00_0018), 1, $urandom);
        step();
        drive(0, '0, 1, 32'h5A5A_A5A5);
        settle();
        chk("tp_after_flush_fresh", 192'(ws_if.bus[63:32]), 192'(32'h5A5A_A5A5));
        tick();

        // capture and ertn flush on the same edge
        drive(1, mk_bus(0, 4'd0, 5'b00000, 0, 1, 5'd10, 32'h1234, 32'h1c00_001c), 1, $urandom);
        wb_ertn = 1'b1;
        step();
        drive(0, '0, 1, $urandom);
        settle();
        chk("tp_ertn_capture", 192'(ws_if.valid), 192'(0));
        tick();

        // reset during a stall
        drive(1, mk_bus(0, 4'd0, 5'b01000, 1, 1, 5'd11, 32'h6001, 32'h1c00_0020), 1, $urandom);
        step();
        drive(0, '0, 0, $urandom);
        step();
        drive(0, '0, 0, $urandom);
        reset = 1'b1;
        step();
        drive(0, '0, 1, $urandom);
        settle();
        chk("tp_reset_fwd", 192'(ms_fwd_bus), 192'(0));
        chk("tp_reset_valid", 192'(ws_if.valid), 192'(0));
        tick();

        for (int i = 0; i < 1500; i++) begin
            k   = $urandom_range(0, 5);
            ld  = (k == 5) ? 5'd0 : 5'(1 << k);
            rfm = (ld != 5'd0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 9) < 7,
                  mk_bus($urandom_range(0, 15) == 0,
                         ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                         ld, rfm, 1'($urandom), 5'($urandom), $urandom, $urandom),
                  $urandom_range(0, 9) < 6, $urandom);
            wb_ex   = ($urandom_range(0, 39) == 0);
            wb_ertn = ($urandom_range(0, 39) == 0);
            reset   = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
